mem_access_stage: RTL
=====================

# mem_access_stage

Parametrised MIPS memory-access pipeline stage, successor to the single-cycle combinational MEM stage. It sits between EX/MEM and WB. It:
- registers all MEM/WB outputs;
- adds byte, halfword and word stores, and signed or unsigned sub-word loads;
- detects misaligned accesses;
- models a data memory with configurable wait states, stalling upstream while a memory access is in flight.

Branch resolution (`pc_src_out`) stays combinational, as before.

## Interface
Parameters:
- `DATA_WIDTH`, 32: datapath width. Fixed at 32 in this generation; other values are illegal.
- `DEPTH_WORDS`, 256: data memory depth in 32-bit words. Must be a power of two.
- `MEM_LATENCY`, 0: extra wait cycles per load/store, range 0..15.

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  EX/MEM slot holds an instruction
- `in_mem_read`, `in_mem_write`  in  1 each  load / store request (never both)
- `in_load_mode`  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
- `in_load_unsigned`  in  1  zero-extend sub-word loads
- `in_address`  in  32  effective byte address
- `in_write_data`  in  32  store data; sub-word stores take the low bits
- `in_mem_to_reg`, `in_reg_write`  in  1 each  WB controls, passed through
- `in_zero`, `in_branch`  in  1 each  ALU zero flag and branch instruction flag
- `in_write_back_destination`  in  5  destination register
- `stall_out`  out  1  upstream must hold; `in_valid` is ignored while this is high
- `pc_src_out`  out  1  take branch
- `out_valid`  out  1  MEM/WB register valid
- `read_data_out`  out  32  extended load data
- `mem_to_reg_out`, `reg_write_out`  out  1 each  registered WB controls
- `address_out`  out  32  registered ALU result
- `write_back_destination_out`  out  5  registered destination register
- `misaligned_out`  out  1  registered; the access was suppressed

## Operation
Addressing:
- Memory is little-endian. Word index is `address[$clog2(DEPTH_WORDS)+1:2]`.
- Upper address bits are ignored, so out-of-range addresses wrap.

Alignment:
- Halfword access requires `address[0]=0`.
- Word access requires `address[1:0]=0`.
- Byte access is always aligned.

Stores:
- Write only the selected byte lanes (byte-enable).
- A misaligned store writes nothing.

Loads:
- Select the addressed byte or half, then sign- or zero-extend per `in_load_unsigned`.
- A misaligned load returns 0.

Non-memory instructions: one registered cycle through to the outputs; no memory access.

Misaligned access:
- `misaligned_out` is 1 for that instruction.
- `reg_write_out` is forced to 0.
- All other outputs follow normal rules.

Branch: `pc_src_out = in_valid & in_branch & in_zero & ~stall_out`.

FSM states are IDLE and BUSY:
- IDLE, accepting a memory op with `MEM_LATENCY>0`: capture all inputs, load the counter with `MEM_LATENCY`, go to BUSY.
- IDLE, accepting a memory op with `MEM_LATENCY=0`: perform the access this edge; outputs update at the same edge.
- BUSY: `stall_out=1`; the counter decrements each cycle. When it reaches 0, perform the access at that edge, load the output registers, return to IDLE.

`out_valid` is registered `in_valid` for a single-cycle op. It is 1 for exactly one cycle per completed memory op. It is 0 in every other cycle, including every BUSY cycle.

## Timing
- Output latency: 1 cycle for non-memory ops; `MEM_LATENCY+1` cycles for loads and stores.
- A store commits to memory on the same edge that its `out_valid` is registered.
- A load issued immediately after a store to the same word sees the new data.
- `stall_out` is high for `MEM_LATENCY` cycles, starting the cycle after accept.
- Reset value of every output register is 0; `stall_out` is 0 (FSM in IDLE).
- Memory contents are not reset.
- Reset during BUSY abandons the pending access. A pending store never writes.

## Structure
- `mips_mem_pkg` holds:
  - the load-mode encodings `LM_WORD`, `LM_HALF`, `LM_BYTE`;
  - the FSM state enum;
  - the function that converts an access mode and address into byte-enables.
- Sub-module `mem_data_ram`: a synchronous-write, asynchronous-read word array with a 4-bit byte-enable.
- Lane selection and extension live in `mem_access_stage`.

## Test plan
- `MEM_LATENCY=2`: SW 0xDEADBEEF to 0x10, then LW from 0x10.
  - `stall_out` high for 2 cycles after each accept.
  - `out_valid` in cycle 3.
  - `read_data_out=0xDEADBEEF`.
- Loads from word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- SB 0x55 to 0x11, then LW 0x10 → 0xDEAD55EF.
- LW from 0x12:
  - `misaligned_out=1`, `reg_write_out=0`, `read_data_out=0`.
  - A following SW to 0x12 leaves word 0x10 unchanged.
- `in_branch=1`, `in_zero=1`, `in_valid=1` in IDLE → `pc_src_out=1` in the same cycle. The same inputs while BUSY → `pc_src_out=0`.
- Reset asserted mid-BUSY during an SW of 0x12345678 to 0x20.
  - All outputs go to 0 immediately.
  - A later LW from 0x20 returns the prior contents.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: access-size encodings,
// FSM state type, the captured request record and byte-lane helpers.
package mips_mem_pkg;

  // Access size encodings carried on in_load_mode (2'b11 behaves as a word).
  localparam logic [1:0] LM_WORD = 2'b00;
  localparam logic [1:0] LM_HALF = 2'b01;
  localparam logic [1:0] LM_BYTE = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Everything about one instruction that the stage must remember while the
  // data memory is busy.
  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_mode;
    logic        load_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  wb_dest;
  } mem_req_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] mode,
                                         input logic [1:0] addr_lo);
    case (mode)
      LM_HALF: return addr_lo[0];
      LM_BYTE: return 1'b0;
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

  // Little-endian byte lanes touched by an access; a misaligned access
  // touches none, so a misaligned store can never corrupt memory.
  function automatic logic [3:0] byte_enables(input logic [1:0] mode,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    case (mode)
      LM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      LM_BYTE: be = 4'b0001 << addr_lo;
      default: be = 4'b1111;
    endcase
    if (is_misaligned(mode, addr_lo)) be = 4'b0000;
    return be;
  endfunction

endpackage

// File: rtl/mem_data_ram.sv
// Word-organised data memory: synchronous byte-enabled write, asynchronous
// read. Contents are undefined until written.
module mem_data_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  // NOTE: the array has no reset; clearing a RAM would need a per-word loop
  // that maps to flops instead of a memory macro, and software never relies
  // on power-up contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: registered MEM/WB outputs, byte/half/word stores, signed or
// unsigned sub-word loads, misalignment suppression and a data memory with
// MEM_LATENCY wait cycles during which upstream is stalled. DATA_WIDTH must
// stay 32 in this generation; DEPTH_WORDS must be a power of two.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [1:0]            in_load_mode,
  input  logic                  in_load_unsigned,
  input  logic [DATA_WIDTH-1:0] in_address,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic                  in_zero,
  input  logic                  in_branch,
  input  logic [4:0]            in_write_back_destination,
  output logic                  stall_out,
  output logic                  pc_src_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic [DATA_WIDTH-1:0] address_out,
  output logic [4:0]            write_back_destination_out,
  output logic                  misaligned_out
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic       HAS_WAIT = (MEM_LATENCY != 0);

  state_e     r_state;
  logic [3:0] r_count;
  mem_req_t   r_cap;

  mem_req_t    w_in_req;
  mem_req_t    w_req;
  logic        w_accept;
  logic        w_in_is_mem;
  logic        w_start_wait;
  logic        w_finish_wait;
  logic        w_do_access;
  logic        w_req_valid;
  logic        w_req_is_mem;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [31:0] w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_in_req = '{
    mem_read:      in_mem_read,
    mem_write:     in_mem_write,
    load_mode:     in_load_mode,
    load_unsigned: in_load_unsigned,
    address:       in_address,
    write_data:    in_write_data,
    mem_to_reg:    in_mem_to_reg,
    reg_write:     in_reg_write,
    wb_dest:       in_write_back_destination
  };

  assign stall_out     = (r_state == ST_BUSY);
  assign pc_src_out    = in_valid & in_branch & in_zero & ~stall_out;

  assign w_accept      = (r_state == ST_IDLE) & in_valid;
  assign w_in_is_mem   = in_mem_read | in_mem_write;
  assign w_start_wait  = w_accept & w_in_is_mem & HAS_WAIT;
  // The counter is loaded with MEM_LATENCY; the access happens on the edge
  // that takes it from 1 to 0, giving MEM_LATENCY stalled cycles.
  assign w_finish_wait = (r_state == ST_BUSY) & (r_count == 4'd1);

  // While busy the captured request drives the memory; otherwise the live
  // EX/MEM inputs do.
  assign w_req         = (r_state == ST_BUSY) ? r_cap : w_in_req;
  assign w_req_valid   = (r_state == ST_BUSY) | in_valid;
  assign w_req_is_mem  = w_req.mem_read | w_req.mem_write;
  assign w_do_access   = (w_accept & w_in_is_mem & ~HAS_WAIT) | w_finish_wait;
  assign w_mis         = w_req_valid & w_req_is_mem
                       & is_misaligned(w_req.load_mode, w_req.address[1:0]);
  // Reset gating keeps an abandoned store from writing if reset spans an edge.
  assign w_be          = (w_do_access & w_req.mem_write & ~reset)
                       ? byte_enables(w_req.load_mode, w_req.address[1:0])
                       : 4'b0000;

  // Replicate sub-word store data across all lanes; byte enables pick one.
  // NOTE: every signal written here gets a value on every path (default arm
  // included) so no latch is inferred.
  always_comb begin
    case (w_req.load_mode)
      LM_HALF: w_wdata = {2{w_req.write_data[15:0]}};
      LM_BYTE: w_wdata = {4{w_req.write_data[7:0]}};
      default: w_wdata = w_req.write_data;
    endcase
  end

  mem_data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_be    (w_be),
    .i_addr  (w_req.address[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Select the addressed byte or halfword and sign/zero extend it.
  always_comb begin
    w_byte = w_rdata[{w_req.address[1:0], 3'b000} +: 8];
    w_half = w_req.address[1] ? w_rdata[31:16] : w_rdata[15:0];
    case (w_req.load_mode)
      LM_HALF: w_lane = {{16{~w_req.load_unsigned & w_half[15]}}, w_half};
      LM_BYTE: w_lane = {{24{~w_req.load_unsigned & w_byte[7]}}, w_byte};
      default: w_lane = w_rdata;
    endcase
  end

  assign w_load_data = (w_req.mem_read & ~w_mis) ? w_lane : 32'd0;

  // Wait-state FSM: capture the request on accept, count down, then release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_cap   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_wait) begin
            r_state <= ST_BUSY;
            r_count <= LAT;
            r_cap   <= w_in_req;
          end
        end
        default: begin
          r_count <= r_count - 4'd1;
          if (w_finish_wait) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: loads when an instruction completes, shows a bubble
  // during waits (other fields hold).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid                  <= 1'b0;
      read_data_out              <= '0;
      mem_to_reg_out             <= 1'b0;
      reg_write_out              <= 1'b0;
      address_out                <= '0;
      write_back_destination_out <= 5'd0;
      misaligned_out             <= 1'b0;
    end else if (w_start_wait || ((r_state == ST_BUSY) && !w_finish_wait)) begin
      out_valid <= 1'b0;
    end else begin
      out_valid                  <= w_req_valid;
      read_data_out              <= w_load_data;
      mem_to_reg_out             <= w_req.mem_to_reg;
      reg_write_out              <= w_req.reg_write & ~w_mis;
      address_out                <= w_req.address;
      write_back_destination_out <= w_req.wb_dest;
      misaligned_out             <= w_mis;
    end
  end

endmodule
